// File: rtl/axil_uart_pkg.sv
// Shared definitions for the AXI4-Lite UART transmitter: register map,
// response codes, STATUS layout and the transmitter state encoding.
package axil_uart_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // STATUS bit positions
    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_BUSY      = 2;
    localparam int unsigned STAT_LEVEL_LSB = 8;

    // Smallest usable bit period in clock cycles
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Raise any divisor below the minimum up to the minimum
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: accepts a byte on valid/ready, shifts it out LSB first
// with a start and stop bit, each bit lasting the divisor latched at accept.
module uart_tx_serializer
    import axil_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] divisor,
    output logic        uart_txd,
    output logic        busy
);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        txd_q, txd_d;
    logic        bit_end;
    logic        load;

    // State register, baud counter, shifter and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_MIN;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    // Next-state logic; the line level is computed one cycle ahead so the
    // start bit appears on the cycle after the byte is accepted
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        div_d    = div_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        txd_d    = txd_q;
        bit_end  = (cnt_q == div_q - 16'd1);
        in_ready = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
        load     = in_valid && in_ready;

        if (state_q != TX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 16'd1;
        end

        case (state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Accepting a byte overrides the idle/stop exit: start bit next cycle
        if (load) begin
            state_d = TX_START;
            cnt_d   = '0;
            div_d   = divisor;
            shift_d = in_data;
            txd_d   = 1'b0;
        end
    end

    assign uart_txd = txd_q;
    assign busy     = (state_q != TX_IDLE);

endmodule

// File: rtl/axil_uart_tx.sv
// AXI4-Lite transmit-only UART: TXDATA/STATUS/DIVISOR registers, a small
// byte FIFO and an 8N1 serializer driving uart_txd.
module axil_uart_tx
    import axil_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] AXI_awaddr,
    input  logic [2:0]  AXI_awprot,
    input  logic        AXI_awvalid,
    output logic        AXI_awready,
    input  logic [31:0] AXI_wdata,
    input  logic [3:0]  AXI_wstrb,
    input  logic        AXI_wvalid,
    output logic        AXI_wready,
    output logic [1:0]  AXI_bresp,
    output logic        AXI_bvalid,
    input  logic        AXI_bready,
    input  logic [31:0] AXI_araddr,
    input  logic [2:0]  AXI_arprot,
    input  logic        AXI_arvalid,
    output logic        AXI_arready,
    output logic [31:0] AXI_rdata,
    output logic [1:0]  AXI_rresp,
    output logic        AXI_rvalid,
    input  logic        AXI_rready,
    output logic        uart_txd,
    output logic        tx_busy
);

    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RESET = clamp_div(16'(CLK_HZ / BAUD));
    localparam logic [PW:0] LVL_FULL  = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] div_q, div_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic [PW:0] level;
    logic        full, empty, push, pop;
    logic        wr_hs, rd_hs;
    logic        ser_ready, ser_busy;
    logic [15:0] div_wr;
    logic [31:0] status_word;
    logic        unused_inputs;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign pop   = ser_ready && !empty;

    assign wr_hs = AXI_awvalid && AXI_wvalid && !bvalid_q;
    assign rd_hs = AXI_arvalid && !rvalid_q;

    assign tx_busy = !empty || ser_busy;

    always_comb begin
        status_word                 = '0;
        status_word[STAT_FULL]      = full;
        status_word[STAT_EMPTY]     = empty;
        status_word[STAT_BUSY]      = tx_busy;
        status_word[STAT_LEVEL_LSB +: 8] = 8'(level);
    end

    // Register state with asynchronous flush
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            div_q    <= DIV_RESET;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            div_q    <= div_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= AXI_wdata[7:0];
        end
    end

    // Write channel decode: fullness is taken from the current level, before
    // any pop in the same cycle
    always_comb begin
        push     = 1'b0;
        div_d    = div_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        div_wr   = div_q;
        if (AXI_wstrb[0]) div_wr[7:0]  = AXI_wdata[7:0];
        if (AXI_wstrb[1]) div_wr[15:8] = AXI_wdata[15:8];

        if (bvalid_q && AXI_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (AXI_awaddr[3:2])
                REG_TXDATA: begin
                    if (AXI_wstrb[0]) begin
                        if (full) bresp_d = RESP_SLVERR;
                        else      push    = 1'b1;
                    end
                end
                REG_STATUS:  ;
                REG_DIVISOR: div_d   = clamp_div(div_wr);
                default:     bresp_d = RESP_SLVERR;
            endcase
        end
        wr_ptr_d = wr_ptr_q + (PW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (PW + 1)'(pop);
    end

    // Read channel decode, sampling register state at the handshake cycle
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rvalid_q && AXI_rready) begin
            rvalid_d = 1'b0;
        end
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (AXI_araddr[3:2])
                REG_TXDATA:  ;
                REG_STATUS:  rdata_d = status_word;
                REG_DIVISOR: rdata_d = {16'd0, div_q};
                default:     rresp_d = RESP_SLVERR;
            endcase
        end
    end

    uart_tx_serializer u_ser (
        .clk      (aclk),
        .rst_n    (aresetn),
        .in_data  (fifo_mem[rd_ptr_q[PW-1:0]]),
        .in_valid (!empty),
        .in_ready (ser_ready),
        .divisor  (div_q),
        .uart_txd (uart_txd),
        .busy     (ser_busy)
    );

    assign AXI_awready = wr_hs;
    assign AXI_wready  = wr_hs;
    assign AXI_bvalid  = bvalid_q;
    assign AXI_bresp   = bresp_q;
    assign AXI_arready = rd_hs;
    assign AXI_rvalid  = rvalid_q;
    assign AXI_rresp   = rresp_q;
    assign AXI_rdata   = rdata_q;

    assign unused_inputs = ^{AXI_awaddr[31:4], AXI_awaddr[1:0], AXI_awprot,
                             AXI_wdata[31:16], AXI_wstrb[3:2],
                             AXI_araddr[31:4], AXI_araddr[1:0], AXI_arprot};

endmodule

// File: tb/tb_axil_uart_tx.sv
// Scoreboard bench for axil_uart_tx: stimulus pushes expected B/R responses
// and transmitted bytes; independent monitors pop and compare them.
module tb_axil_uart_tx;

    typedef struct {
        string       name;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] AXI_awaddr = '0;
    logic [2:0]  AXI_awprot = '0;
    logic        AXI_awvalid = 1'b0;
    logic        AXI_awready;
    logic [31:0] AXI_wdata = '0;
    logic [3:0]  AXI_wstrb = '0;
    logic        AXI_wvalid = 1'b0;
    logic        AXI_wready;
    logic [1:0]  AXI_bresp;
    logic        AXI_bvalid;
    logic        AXI_bready = 1'b1;
    logic [31:0] AXI_araddr = '0;
    logic [2:0]  AXI_arprot = '0;
    logic        AXI_arvalid = 1'b0;
    logic        AXI_arready;
    logic [31:0] AXI_rdata;
    logic [1:0]  AXI_rresp;
    logic        AXI_rvalid;
    logic        AXI_rready = 1'b1;
    logic        uart_txd;
    logic        tx_busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   cur_div = 868;
    int   busy_fall_cyc = -1;
    logic prev_busy = 1'b0;

    exp_t       b_q[$];
    exp_t       r_q[$];
    logic [7:0] byte_q[$];
    int         frame_starts[$];

    axil_uart_tx #(
        .CLK_HZ     (100_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (16)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awprot  (AXI_awprot),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_wdata   (AXI_wdata),
        .AXI_wstrb   (AXI_wstrb),
        .AXI_wvalid  (AXI_wvalid),
        .AXI_wready  (AXI_wready),
        .AXI_bresp   (AXI_bresp),
        .AXI_bvalid  (AXI_bvalid),
        .AXI_bready  (AXI_bready),
        .AXI_araddr  (AXI_araddr),
        .AXI_arprot  (AXI_arprot),
        .AXI_arvalid (AXI_arvalid),
        .AXI_arready (AXI_arready),
        .AXI_rdata   (AXI_rdata),
        .AXI_rresp   (AXI_rresp),
        .AXI_rvalid  (AXI_rvalid),
        .AXI_rready  (AXI_rready),
        .uart_txd    (uart_txd),
        .tx_busy     (tx_busy)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        failures++;
        $display("FAIL %s %s", name, why);
    endtask

    // B channel scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && AXI_bvalid && AXI_bready) begin
                if (b_q.size() == 0) fail_now("b_unexpected", "no response was expected");
                else begin
                    e = b_q.pop_front();
                    check(e.name, {30'd0, AXI_bresp}, {30'd0, e.resp});
                end
            end
        end
    end

    // R channel scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && AXI_rvalid && AXI_rready) begin
                if (r_q.size() == 0) fail_now("r_unexpected", "no response was expected");
                else begin
                    e = r_q.pop_front();
                    check({e.name, "_rresp"}, {30'd0, AXI_rresp}, {30'd0, e.resp});
                    check({e.name, "_rdata"}, AXI_rdata, e.data);
                end
            end
        end
    end

    // Serial line monitor: checks every cycle of each frame against the
    // expected bit for the divisor in force when the frame began
    initial begin
        logic [7:0] exp_b, got;
        int d, bad, b;
        bit aborted;
        forever begin
            @(negedge aclk);
            if (aresetn && uart_txd == 1'b0) begin
                frame_starts.push_back(cyc);
                exp_b = 8'h00;
                if (byte_q.size() == 0) fail_now("uart_unexpected_frame", "start bit with nothing queued");
                else exp_b = byte_q.pop_front();
                d = cur_div;
                bad = 0;
                got = '0;
                aborted = 1'b0;
                for (int k = 0; k < 10 * d; k++) begin
                    if (k > 0) @(negedge aclk);
                    if (!aresetn) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = k / d;
                    if (b == 0) begin
                        if (uart_txd !== 1'b0) bad++;
                    end else if (b == 9) begin
                        if (uart_txd !== 1'b1) bad++;
                    end else begin
                        if (uart_txd !== exp_b[b-1]) bad++;
                        if (k % d == 0) got[b-1] = uart_txd;
                    end
                end
                if (!aborted) begin
                    check("uart_byte", {24'd0, got}, {24'd0, exp_b});
                    check("uart_bit_errors", bad, 0);
                end
            end
        end
    end

    // tx_busy falling-edge timestamp
    always @(negedge aclk) begin
        if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
        prev_busy = tx_busy;
    end

    task automatic wait_aw();
        int n = 0;
        #1;
        while (!AXI_awready && n < 200) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (!AXI_awready) fail_now("aw_timeout", "awready never asserted");
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input string name, input logic [1:0] resp);
        exp_t e;
        e.name = name;
        e.resp = resp;
        e.data = '0;
        b_q.push_back(e);
        @(negedge aclk);
        AXI_awaddr  = addr;
        AXI_wdata   = data;
        AXI_wstrb   = strb;
        AXI_awvalid = 1'b1;
        AXI_wvalid  = 1'b1;
        wait_aw();
        @(posedge aclk);
        @(negedge aclk);
        AXI_awvalid = 1'b0;
        AXI_wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input string name,
                            input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        int n = 0;
        e.name = name;
        e.resp = resp;
        e.data = data;
        r_q.push_back(e);
        @(negedge aclk);
        AXI_araddr  = addr;
        AXI_arvalid = 1'b1;
        #1;
        while (!AXI_arready && n < 200) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (!AXI_arready) fail_now("ar_timeout", "arready never asserted");
        @(posedge aclk);
        @(negedge aclk);
        AXI_arvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        repeat (3) @(negedge aclk);
        while (tx_busy && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (tx_busy) fail_now(name, "tx_busy did not clear in budget");
        repeat (2) @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("reset_txd", {31'd0, uart_txd}, 32'd1);
        b_q.delete();
        r_q.delete();
        byte_q.delete();
        cur_div = 868;
        repeat (3) @(negedge aclk);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2;

        // Reset state
        repeat (3) @(negedge aclk);
        check("reset_txd_idle", {31'd0, uart_txd}, 32'd1);
        check("reset_bvalid", {31'd0, AXI_bvalid}, 32'd0);
        check("reset_rvalid", {31'd0, AXI_rvalid}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        axi_read(32'h4, "rst_status", 2'b00, 32'h0000_0002);
        axi_read(32'h8, "rst_divisor", 2'b00, 32'd868);

        // Single frame 0x55 at divisor 4
        axi_write(32'h8, 32'd4, 4'hF, "wr_div4", 2'b00);
        cur_div = 4;
        byte_q.push_back(8'h55);
        axi_write(32'h0, 32'h55, 4'hF, "wr_tx55", 2'b00);
        wait_idle(500, "idle_55");
        if (frame_starts.size() < 1) fail_now("frame55_seen", "no frame observed");
        else check("busy_fall_55", busy_fall_cyc, frame_starts[$] + 40);
        check("idle_high_55", {31'd0, uart_txd}, 32'd1);

        // Back-to-back frames 0xA1, 0x0F
        byte_q.push_back(8'hA1);
        byte_q.push_back(8'h0F);
        axi_write(32'h0, 32'hA1, 4'h1, "wr_txA1", 2'b00);
        axi_write(32'h0, 32'h0F, 4'h1, "wr_tx0F", 2'b00);
        wait_idle(1000, "idle_b2b");
        if (frame_starts.size() < 3) fail_now("b2b_frames_seen", "fewer than two frames");
        else begin
            s1 = frame_starts[$-1];
            s2 = frame_starts[$];
            check("b2b_gap", s2 - s1, 40);
            check("b2b_busy_fall", busy_fall_cyc, s2 + 40);
        end

        // Divisor clamp, reserved, read-only, strobe and upper-address cases
        axi_write(32'h8, 32'd0, 4'hF, "wr_div0", 2'b00);
        cur_div = 2;
        axi_read(32'h8, "rd_div_clamped", 2'b00, 32'd2);
        axi_read(32'hC, "rd_rsvd", 2'b10, 32'd0);
        axi_write(32'hC, 32'h1234, 4'hF, "wr_rsvd", 2'b10);
        axi_write(32'h4, 32'hFFFF, 4'hF, "wr_status", 2'b00);
        axi_read(32'h4, "rd_status_unchanged", 2'b00, 32'h0000_0002);
        axi_read(32'h0, "rd_txdata", 2'b00, 32'd0);
        axi_read(32'h1000_0008, "rd_div_alias", 2'b00, 32'd2);
        axi_write(32'h0, 32'h77, 4'hE, "wr_tx_nostrb", 2'b00);
        repeat (30) @(negedge aclk);
        check("nostrb_no_push", {31'd0, tx_busy}, 32'd0);

        // Fill the FIFO behind a stalled frame
        axi_write(32'h8, 32'hFFFF, 4'hF, "wr_divFFFF", 2'b00);
        cur_div = 65535;
        byte_q.push_back(8'h11);
        axi_write(32'h0, 32'h11, 4'h1, "wr_prime", 2'b00);
        repeat (3) @(negedge aclk);
        for (int i = 0; i < 17; i++) begin
            axi_write(32'h0, 32'(i), 4'h1, (i < 16) ? "wr_fill_ok" : "wr_fill_full",
                      (i < 16) ? 2'b00 : 2'b10);
        end
        axi_read(32'h4, "rd_status_full", 2'b00, 32'h0000_1005);

        // bvalid back-pressure blocks further writes
        b_q.push_back('{name: "wr_hold_a", resp: 2'b00, data: 32'd0});
        b_q.push_back('{name: "wr_hold_b", resp: 2'b00, data: 32'd0});
        @(posedge aclk);
        #2 AXI_bready = 1'b0;
        @(negedge aclk);
        AXI_awaddr  = 32'h4;
        AXI_wdata   = 32'h0;
        AXI_wstrb   = 4'hF;
        AXI_awvalid = 1'b1;
        AXI_wvalid  = 1'b1;
        wait_aw();
        @(posedge aclk);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("hold_awready", {31'd0, AXI_awready}, 32'd0);
            check("hold_wready", {31'd0, AXI_wready}, 32'd0);
        end
        check("hold_bvalid", {31'd0, AXI_bvalid}, 32'd1);
        @(posedge aclk);
        #2 AXI_bready = 1'b1;
        @(negedge aclk);
        wait_aw();
        @(posedge aclk);
        @(negedge aclk);
        AXI_awvalid = 1'b0;
        AXI_wvalid  = 1'b0;
        repeat (3) @(negedge aclk);

        do_reset();
        axi_read(32'h4, "rd_status_after_flush", 2'b00, 32'h0000_0002);

        // Reset in the middle of a frame
        axi_write(32'h8, 32'd4, 4'hF, "wr_div4_b", 2'b00);
        cur_div = 4;
        byte_q.push_back(8'h3C);
        axi_write(32'h0, 32'h3C, 4'h1, "wr_tx3C", 2'b00);
        repeat (15) @(negedge aclk);
        check("midframe_busy", {31'd0, tx_busy}, 32'd1);
        do_reset();
        axi_read(32'h4, "rd_status_midreset", 2'b00, 32'h0000_0002);
        axi_read(32'h8, "rd_div_midreset", 2'b00, 32'd868);

        repeat (5) @(negedge aclk);
        check("sb_b_drained", b_q.size(), 0);
        check("sb_r_drained", r_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_uart_tx.md
# axil_uart_tx

AXI4-Lite responder that accepts bytes from the Z80 bus bridge and serialises them onto a UART TX pin in 8N1 format through a small FIFO. It sits on the same `AXI_*` bus as the existing UART wrapper, running in the 100 MHz AXI domain. It provides a buffered, software-visible transmit channel with status and a programmable baud divisor.

## Interface
- `CLK_HZ`, 100_000_000, aclk frequency.
- `BAUD`, 115200, reset baud rate; reset divisor = CLK_HZ/BAUD, truncated.
- `FIFO_DEPTH`, 16, TX FIFO entries; must be a power of two, ≥2.
- `aclk` in 1: single clock; all logic is on its rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `AXI_awaddr` in 32, `AXI_awprot` in 3 (ignored), `AXI_awvalid` in 1, `AXI_awready` out 1.
- `AXI_wdata` in 32, `AXI_wstrb` in 4, `AXI_wvalid` in 1, `AXI_wready` out 1.
- `AXI_bresp` out 2, `AXI_bvalid` out 1, `AXI_bready` in 1.
- `AXI_araddr` in 32, `AXI_arprot` in 3 (ignored), `AXI_arvalid` in 1, `AXI_arready` out 1.
- `AXI_rdata` out 32, `AXI_rresp` out 2, `AXI_rvalid` out 1, `AXI_rready` in 1.
- `uart_txd` out 1: serial output, idle high.
- `tx_busy` out 1: high when the FIFO is non-empty or a frame is in progress.

## Operation
- Decoding uses `addr[3:2]` only; upper bits are ignored.
  - 0x0 TXDATA: a write with `wstrb[0]`=1 pushes `wdata[7:0]`. Reads return 0.
  - 0x4 STATUS (read-only): bit0 full, bit1 empty, bit2 `tx_busy`, bits[15:8] FIFO level. Writes are ignored and answered OKAY.
  - 0x8 DIVISOR: R/W in bits[15:0]. A written value below 2 is stored as 2.
  - 0xC: reserved. Reads and writes get SLVERR; reads return 0.
- Write to TXDATA while the FIFO is full: the byte is dropped and `bresp`=SLVERR. Fullness is judged before any same-cycle pop.
- TXDATA write with `wstrb[0]`=0: no push, OKAY.
- Transmitter states: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each bit lasts DIVISOR cycles.
  - DIVISOR is latched at the pop; a change takes effect on the next frame.
  - In IDLE, if the FIFO is non-empty, pop and go to START.
  - When STOP ends and the FIFO is non-empty, pop directly into START (back-to-back, no idle gap).

## Timing
- Reset values: all `*ready`, `bvalid`, `rvalid` = 0; `bresp`, `rresp`, `rdata` = 0; `uart_txd` = 1; `tx_busy` = 0; FIFO empty; DIVISOR = CLK_HZ/BAUD.
- Write channel:
  - `AXI_awready` and `AXI_wready` pulse together for one cycle T, only when `awvalid`, `wvalid` and !`bvalid`.
  - Side effect (push or DIVISOR update) and `bvalid` both appear at T+1.
  - `bvalid` holds until `bready`; no new write is accepted while `bvalid`=1.
- Read channel:
  - `AXI_arready` pulses at T when `arvalid` and !`rvalid`.
  - `rvalid`/`rdata` are registered at T+1 and held until `rready`.
  - STATUS reflects state at T.
- Serial timing:
  - Pop at cycle P; `uart_txd` goes low at P+1.
  - The frame is 10×DIVISOR cycles; the stop bit is high.
  - `tx_busy` deasserts the cycle after the stop bit ends with the FIFO empty.
- Simultaneous push and pop on a non-full FIFO: both occur; the level is unchanged.
- Reset asserted mid-frame: `uart_txd`=1 immediately; FIFO flushed; any pending `bvalid`/`rvalid` dropped.

## Structure
- Package `axil_uart_pkg`:
  - register offsets;
  - `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10;
  - STATUS bit positions;
  - transmitter state enum.
- Sub-module `uart_tx_serializer`: byte in with valid/ready, divisor in, `uart_txd` out; contains the state machine and baud counter.
- FIFO pointers, AXI handshake and register decoding live in the top.

## Test plan
- Reset → `uart_txd`=1, STATUS read = 0x0000_0002, DIVISOR read = 868 (100 MHz/115200).
- DIVISOR=4, write 0x55 to TXDATA → `uart_txd` shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), then idles high; `bresp`=OKAY.
- DIVISOR=4, write 0xA1, 0x0F back-to-back → two contiguous frames with no idle between stop and start; `tx_busy` falls exactly 1 cycle after the second stop bit.
- Push 17 bytes with a stalled transmitter (DIVISOR=0xFFFF) → first 16 OKAY, 17th SLVERR; STATUS bit0=1, level=16.
- Write DIVISOR=0 → readback 2. Read 0xC → `rresp`=SLVERR, `rdata`=0.
- Hold `bready`=0 for 5 cycles while new AW/W are valid → `awready`/`wready` stay 0 until `bvalid` clears. Assert `aresetn` low mid-frame → `uart_txd`=1 and STATUS shows the FIFO empty after release.
